// File: rtl/kch_pkg.sv
// Purpose : shared types and constants for the known-cluster-head (KCH) table controller.
// Latency : n/a (types and constants only).
// Backpressure: n/a.
package kch_pkg;

   // Default field width of a table record.
   localparam int KCH_W = 16;

   // ID 0 is reserved to mean "no cluster head".
   localparam int CH_ID_NONE = 0;

   // Hop count reported when no cluster head is known.
   localparam logic [KCH_W-1:0] HOPS_INF = '1;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_SEARCH,
      ST_WRITE,
      ST_SCAN,
      ST_DONE
   } kch_state_t;

   // Field order {id, hops, qvalue} is also the packing kch_better expects.
   typedef struct packed {
      logic [KCH_W-1:0] id;
      logic [KCH_W-1:0] hops;
      logic [KCH_W-1:0] qvalue;
   } ch_entry_t;

endpackage

// File: rtl/kch_better.sv
// Purpose : election ordering, true when entry a is a better cluster head than entry b.
// Latency : combinational.
// Backpressure: none.
// Ports   : a, b - packed {id, hops, qvalue}, W bits per field; a_beats_b - ordering result.
module kch_better #(
   parameter int W = 16
) (
   input  logic [3*W-1:0] a,
   input  logic [3*W-1:0] b,
   output logic           a_beats_b
);

   logic [W-1:0] a_id, a_hops, a_q;
   logic [W-1:0] b_id, b_hops, b_q;

   assign {a_id, a_hops, a_q} = a;
   assign {b_id, b_hops, b_q} = b;

   // Fewer hops wins; then higher Q; then lower ID so the result is deterministic.
   always_comb begin
      a_beats_b = 1'b0;
      if (a_hops < b_hops) begin
         a_beats_b = 1'b1;
      end else if (a_hops == b_hops) begin
         if (a_q > b_q) begin
            a_beats_b = 1'b1;
         end else if (a_q == b_q) begin
            a_beats_b = (a_id < b_id);
         end
      end
   end

endmodule

// File: rtl/kch_sched.sv
// Purpose : KCH table controller: dedup/update/append of incoming records, best-CH election on request.
// Latency : record visible at T+k+2 (k = entries searched); election sel_done at T+ch_count+1.
// Backpressure: rec_ready low outside IDLE, during HB_reset and while sel_start is asserted.
// Ports   : clk/nrst (sync, active-low); HB_reset clears the table and aborts any operation;
//           rec_valid/rec_ready + rec_id/rec_hops/rec_qvalue record input;
//           sel_start/sel_busy/sel_done election control; chosenCH/hopsfromCH/chosenQ/no_ch result;
//           ch_count/table_full occupancy; drop_cnt (only when KCH_DROP_CNT_EN is defined).
module kch_sched
   import kch_pkg::*;
#(
   parameter int WORD_WIDTH = 16,
   parameter int NUM_CH     = 16,
   localparam int IDX_W     = $clog2(NUM_CH)
) (
   input  logic                  clk,
   input  logic                  nrst,
   input  logic                  HB_reset,
   input  logic                  rec_valid,
   output logic                  rec_ready,
   input  logic [WORD_WIDTH-1:0] rec_id,
   input  logic [WORD_WIDTH-1:0] rec_hops,
   input  logic [WORD_WIDTH-1:0] rec_qvalue,
   input  logic                  sel_start,
   output logic                  sel_busy,
   output logic                  sel_done,
   output logic [WORD_WIDTH-1:0] chosenCH,
   output logic [WORD_WIDTH-1:0] hopsfromCH,
   output logic [WORD_WIDTH-1:0] chosenQ,
   output logic                  no_ch,
`ifdef KCH_DROP_CNT_EN
   output logic [7:0]            drop_cnt,
`endif
   output logic [IDX_W:0]        ch_count,
   output logic                  table_full
);

   typedef struct packed {
      logic [WORD_WIDTH-1:0] id;
      logic [WORD_WIDTH-1:0] hops;
      logic [WORD_WIDTH-1:0] qvalue;
   } entry_t;

   entry_t           tbl [NUM_CH];
   kch_state_t       state;
   logic [IDX_W-1:0] idx;
   logic [IDX_W-1:0] wr_idx;
   logic             append;
   entry_t           lat;
   entry_t           best;
   entry_t           cand;
   entry_t           scan_best;
   logic             cand_wins;
   logic             last_idx;
   logic             accept;
   logic             id_zero;

   assign cand       = tbl[idx];
   assign last_idx   = ({1'b0, idx} == (ch_count - 1'b1));
   assign rec_ready  = (state == ST_IDLE) && !HB_reset && !sel_start;
   assign sel_busy   = (state != ST_IDLE);
   assign table_full = (ch_count == (IDX_W+1)'(NUM_CH));
   assign accept     = rec_valid && rec_ready;
   assign id_zero    = (rec_id == WORD_WIDTH'(CH_ID_NONE));

   kch_better #(.W(WORD_WIDTH)) u_better (
      .a         (cand),
      .b         (best),
      .a_beats_b (cand_wins)
   );

   // Entry 0 seeds the running best; later entries replace it only when strictly better.
   assign scan_best = ((idx == '0) || cand_wins) ? cand : best;

   always_ff @(posedge clk) begin
      if (!nrst) begin
         state      <= ST_IDLE;
         ch_count   <= '0;
         idx        <= '0;
         wr_idx     <= '0;
         append     <= 1'b0;
         lat        <= '0;
         best       <= '0;
         chosenCH   <= WORD_WIDTH'(CH_ID_NONE);
         hopsfromCH <= '1;
         chosenQ    <= '0;
         no_ch      <= 1'b1;
         sel_done   <= 1'b0;
      end else if (HB_reset) begin
         // Election results are deliberately left holding their last values.
         state    <= ST_IDLE;
         ch_count <= '0;
         idx      <= '0;
         sel_done <= 1'b0;
      end else begin
         sel_done <= 1'b0;
         case (state)
            ST_IDLE: begin
               if (sel_start) begin
                  idx <= '0;
                  if (ch_count == '0) begin
                     chosenCH   <= WORD_WIDTH'(CH_ID_NONE);
                     hopsfromCH <= '1;
                     chosenQ    <= '0;
                     no_ch      <= 1'b1;
                     sel_done   <= 1'b1;
                     state      <= ST_DONE;
                  end else begin
                     state <= ST_SCAN;
                  end
               end else if (accept && !id_zero) begin
                  lat <= '{id: rec_id, hops: rec_hops, qvalue: rec_qvalue};
                  idx <= '0;
                  if (ch_count == '0) begin
                     wr_idx <= '0;
                     append <= 1'b1;
                     state  <= ST_WRITE;
                  end else begin
                     state <= ST_SEARCH;
                  end
               end
            end
            ST_SEARCH: begin
               if (cand.id == lat.id) begin
                  wr_idx <= idx;
                  append <= 1'b0;
                  state  <= ST_WRITE;
               end else if (last_idx) begin
                  if (table_full) begin
                     state <= ST_IDLE;
                  end else begin
                     // Not full, so ch_count fits in the index width.
                     wr_idx <= ch_count[IDX_W-1:0];
                     append <= 1'b1;
                     state  <= ST_WRITE;
                  end
               end else begin
                  idx <= idx + 1'b1;
               end
            end
            ST_WRITE: begin
               if (append) begin
                  ch_count <= ch_count + 1'b1;
               end
               state <= ST_IDLE;
            end
            ST_SCAN: begin
               best <= scan_best;
               if (last_idx) begin
                  // Results are registered together with sel_done so they are valid on the pulse.
                  chosenCH   <= scan_best.id;
                  hopsfromCH <= scan_best.hops;
                  chosenQ    <= scan_best.qvalue;
                  no_ch      <= 1'b0;
                  sel_done   <= 1'b1;
                  state      <= ST_DONE;
               end else begin
                  idx <= idx + 1'b1;
               end
            end
            ST_DONE: begin
               state <= ST_IDLE;
            end
            default: begin
               state <= ST_IDLE;
            end
         endcase
      end
   end

   // Storage is not reset; only entries below ch_count are ever considered valid.
   always_ff @(posedge clk) begin
      if (nrst && !HB_reset && (state == ST_WRITE)) begin
         tbl[wr_idx] <= lat;
      end
   end

`ifdef KCH_DROP_CNT_EN
   logic drop_evt;

   assign drop_evt = (accept && id_zero) ||
                     ((state == ST_SEARCH) && (cand.id != lat.id) && last_idx && table_full);

   always_ff @(posedge clk) begin
      if (!nrst || HB_reset) begin
         drop_cnt <= '0;
      end else if (drop_evt && (drop_cnt != 8'hFF)) begin
         drop_cnt <= drop_cnt + 1'b1;
      end
   end
`endif

endmodule

// File: doc/kch_sched.md
# kch_sched

Sequencing controller for the known-cluster-head (KCH) table. Ingests CHE/INV-derived records (ID, hops, Q-value) over a valid/ready handshake. Performs dedup and update through a sequential table search, and on request scans the table to elect the best cluster head. Sits between the packet-parse front end and the routing/TX logic; HB_reset clears the table for each heartbeat round.

## Interface
Parameters
- WORD_WIDTH, 16, width of ID/hops/Q fields
- NUM_CH, 16, table depth (power of two, ≥2)
- IDX_W, $clog2(NUM_CH), index width (derived, not overridden)

Ports
- clk, in, 1, clock
- nrst, in, 1, reset, synchronous, active-low
- HB_reset, in, 1, clear table and abort any operation
- rec_valid, in, 1, record offered
- rec_ready, out, 1, record accepted when rec_valid & rec_ready
- rec_id / rec_hops / rec_qvalue, in, WORD_WIDTH each, record fields
- sel_start, in, 1, request election (sampled in IDLE only)
- sel_busy, out, 1, state ≠ IDLE
- sel_done, out, 1, one-cycle pulse when election result is valid
- chosenCH, out, WORD_WIDTH, elected CH ID
- hopsfromCH, out, WORD_WIDTH, elected CH hop count
- chosenQ, out, WORD_WIDTH, elected CH Q-value
- no_ch, out, 1, last election found an empty table
- ch_count, out, IDX_W+1, valid entries held
- table_full, out, 1, ch_count == NUM_CH

## Operation
- States: IDLE, SEARCH, WRITE, SCAN, DONE.
- IDLE priority: HB_reset > sel_start > rec_valid. rec_ready = (state==IDLE) & !HB_reset & !sel_start.
- Accepted record, rec_id == 0: discarded (ID 0 is reserved as "none"); stay IDLE.
- Accepted record, ch_count == 0: go directly to WRITE at index 0.
- Accepted record, otherwise: go to SEARCH. Compare entry[idx].id with the latched ID, idx = 0..ch_count-1, one entry per cycle.
  - On match: WRITE overwrites hops and Q at idx.
  - No match and not full: WRITE appends at ch_count, then ch_count++.
  - No match and full: record dropped, return to IDLE.
- WRITE lasts 1 cycle, then returns to IDLE.
- SCAN: visits idx 0..ch_count-1, one per cycle, and keeps a running best. Entry A beats best B if any of the following holds (all unsigned):
  - A.hops < B.hops;
  - hops equal and A.q > B.q;
  - hops and Q equal and A.id < B.id.
- Entry 0 seeds the best. DONE then registers the best into the outputs, pulses sel_done, clears no_ch, and returns to IDLE.
- sel_start with ch_count == 0: go directly to DONE. Outputs become chosenCH=0, hopsfromCH=all-ones, chosenQ=0, no_ch=1.
- HB_reset in any state, next cycle: ch_count=0, state=IDLE, no sel_done pulse. chosenCH/hopsfromCH/chosenQ/no_ch hold their values.
- Table storage need not be reset; validity is determined solely by ch_count.

## Timing
- Reset values: state IDLE, ch_count 0, chosenCH 0, hopsfromCH all-ones, chosenQ 0, no_ch 1, sel_done 0, table_full 0, sel_busy 0, rec_ready 1.
- Record latency: accept at cycle T. Update or append is visible in ch_count/table at T+k+2, where k is the number of entries searched (k=0 for an empty table). rec_ready is high again on the cycle the state returns to IDLE.
- Election latency: sel_start at T, sel_done at T+ch_count+1. Outputs are valid from the sel_done cycle onward.
- The table is frozen during SCAN; no records are accepted until the election completes.
- rec_* fields are latched on acceptance; the source may change them afterward.

## Configuration
- KCH_DROP_CNT_EN defined: adds output drop_cnt, 8 bits, saturating at 255. It increments on every full-table drop and every ID-0 discard, and clears on nrst or HB_reset.
- KCH_DROP_CNT_EN undefined: port and logic are absent; behaviour is otherwise identical.

## Structure
- Package kch_pkg holds:
  - typedef ch_entry_t {id, hops, qvalue};
  - state enum kch_state_t;
  - constants CH_ID_NONE = 0 and HOPS_INF = all-ones.
- Sub-module kch_better: combinational (a, b) -> a_beats_b implementing the election ordering. It is reused by the scan path and unit-tested standalone.

## Test plan
- Reset, then sel_start with an empty table -> sel_done 1 cycle later; no_ch=1, chosenCH=0, hopsfromCH=16'hFFFF.
- Records {5,3,10}, {7,2,4}, {9,2,8}, then sel_start -> chosenCH=9, hopsfromCH=2, chosenQ=8; sel_done exactly 4 cycles after start.
- Records {4,2,8}, {3,2,8}, then select -> chosenCH=3 (ID tiebreak). Then update {3,5,8} and select again -> chosenCH=4; ch_count stays 2.
- Fill 16 distinct IDs, then offer ID 99 -> dropped; ch_count=16, table_full=1; drop_cnt=1 if KCH_DROP_CNT_EN is defined. ID 0 is also discarded.
- HB_reset mid-SCAN -> no sel_done; ch_count=0 next cycle; previous chosenCH held; rec_ready=1.
- rec_valid and sel_start asserted together in IDLE -> election runs, record not accepted (rec_ready=0). The record is accepted after sel_done.
